// File: rtl/rst_seq_pkg.sv
// Shared types and default timing constants for the reset sequencer.
//   seq_state_e : sequencer FSM state (power-on wait, staged release, running)
//   Def*        : default parameter values used by rst_seq_gen
package rst_seq_pkg;

  typedef enum logic [1:0] {
    StPor,
    StRel,
    StRun
  } seq_state_e;

  localparam int unsigned DefNumCh    = 4;
  localparam int unsigned DefCntW     = 16;
  localparam int unsigned DefPorDly   = 12;
  localparam int unsigned DefStageDly = 8;
  localparam int unsigned DefSwRstCyc = 4;
  localparam int unsigned DefWdtTo    = 32;

endpackage

// File: rtl/rst_sync.sv
// Two-flop reset synchroniser: asserts asynchronously, deasserts after two
// rising clock edges with the raw reset released.
//   clk_i  : clock
//   rst_ni : raw asynchronous active-low reset
//   rst_no : synchronised active-low reset
module rst_sync (
  input  logic clk_i,
  input  logic rst_ni,
  output logic rst_no
);

  logic [1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], 1'b1};
    end
  end

  assign rst_no = sync_q[1];

endmodule

// File: rtl/rst_seq_gen.sv
// Staged reset sequencer. After reset release, channel 0 leaves reset after
// POR_DLY cycles and each further channel STAGE_DLY cycles later. Once all
// channels are out (RUN), a rising edge of sw_rst_req[k] pulses channel k low
// for SW_RST_CYC cycles and acknowledges with a one-cycle sw_rst_ack[k].
//   osc_clk    : clock
//   sys_rstn   : asynchronous active-low reset
//   sw_rst_req : per-channel software reset request (edge-detected)
//   ch_rstn    : per-channel active-low reset outputs
//   sw_rst_ack : per-channel completion pulse
//   seq_done   : all channels released and sequencer running
// Optional macro RST_SEQ_WDT_EN adds a watchdog (WDT_TO, wdt_kick, wdt_fired)
// that restarts the whole sequence if not kicked within WDT_TO cycles of RUN.
module rst_seq_gen
  import rst_seq_pkg::*;
#(
  parameter int unsigned NUM_CH     = DefNumCh,
  parameter int unsigned CNT_W      = DefCntW,
  parameter int unsigned POR_DLY    = DefPorDly,
  parameter int unsigned STAGE_DLY  = DefStageDly,
`ifdef RST_SEQ_WDT_EN
  parameter int unsigned WDT_TO     = DefWdtTo,
`endif
  parameter int unsigned SW_RST_CYC = DefSwRstCyc
) (
  input  logic              osc_clk,
  input  logic              sys_rstn,
  input  logic [NUM_CH-1:0] sw_rst_req,
`ifdef RST_SEQ_WDT_EN
  input  logic              wdt_kick,
  output logic              wdt_fired,
`endif
  output logic [NUM_CH-1:0] ch_rstn,
  output logic [NUM_CH-1:0] sw_rst_ack,
  output logic              seq_done
);

  localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
  localparam logic [CNT_W-1:0] PorLast   = CNT_W'(POR_DLY - 1);
  localparam logic [CNT_W-1:0] StageLast = CNT_W'(STAGE_DLY - 1);
  localparam logic [CNT_W-1:0] SwLast    = CNT_W'(SW_RST_CYC - 1);
  localparam logic [2:0]       LastStage = 3'(NUM_CH - 1);

  logic rstn_s;

  rst_sync u_rst_sync (
    .clk_i  (osc_clk),
    .rst_ni (sys_rstn),
    .rst_no (rstn_s)
  );

  seq_state_e                   state_q, state_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [2:0]                   stage_q, stage_d;
  logic [NUM_CH-1:0]            ch_rel_q, ch_rel_d;      // released by the power-on sequence
  logic [NUM_CH-1:0]            ch_rstn_q, ch_rstn_d;
  logic                         seq_done_q, seq_done_d;
  logic [NUM_CH-1:0]            req_q;                   // previous-cycle request sample
  logic [NUM_CH-1:0]            sw_busy_q, sw_busy_d;
  logic [NUM_CH-1:0][CNT_W-1:0] sw_cnt_q, sw_cnt_d;
  logic [NUM_CH-1:0]            ack_q, ack_d;
`ifdef RST_SEQ_WDT_EN
  logic [CNT_W-1:0]             wdt_cnt_q, wdt_cnt_d;
  logic                         wdt_fire_q, wdt_fire_d;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    stage_d    = stage_q;
    ch_rel_d   = ch_rel_q;
    seq_done_d = seq_done_q;
    sw_busy_d  = sw_busy_q;
    sw_cnt_d   = sw_cnt_q;
    ack_d      = '0;

    unique case (state_q)
      StPor: begin
        if (cnt_q == PorLast) begin
          ch_rel_d[0] = 1'b1;
          cnt_d       = '0;
          stage_d     = 3'd1;
          if (NUM_CH == 1) begin
            state_d    = StRun;
            seq_done_d = 1'b1;
          end else begin
            state_d = StRel;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRel: begin
        if (cnt_q == StageLast) begin
          for (int k = 0; k < NUM_CH; k++) begin
            if (stage_q == 3'(k)) ch_rel_d[k] = 1'b1;
          end
          cnt_d   = '0;
          stage_d = stage_q + 3'd1;
          if (stage_q == LastStage) begin
            state_d    = StRun;
            seq_done_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StRun: ;
      default: state_d = StPor;
    endcase

    // Software resets: only a fresh 0->1 edge on an idle channel in RUN starts one.
    for (int k = 0; k < NUM_CH; k++) begin
      if (sw_busy_q[k]) begin
        if (sw_cnt_q[k] == SwLast) begin
          sw_busy_d[k] = 1'b0;
          sw_cnt_d[k]  = '0;
          ack_d[k]     = 1'b1;
        end else begin
          sw_cnt_d[k] = sw_cnt_q[k] + CntOne;
        end
      end else if ((state_q == StRun) && sw_rst_req[k] && !req_q[k]) begin
        sw_busy_d[k] = 1'b1;
        sw_cnt_d[k]  = '0;
      end
    end

`ifdef RST_SEQ_WDT_EN
    // Watchdog expiry overrides everything and restarts from power-on.
    wdt_cnt_d  = '0;
    wdt_fire_d = 1'b0;
    if ((state_q == StRun) && !wdt_kick) begin
      if (wdt_cnt_q == CNT_W'(WDT_TO - 1)) begin
        wdt_fire_d = 1'b1;
        state_d    = StPor;
        cnt_d      = '0;
        stage_d    = '0;
        ch_rel_d   = '0;
        seq_done_d = 1'b0;
        sw_busy_d  = '0;
        sw_cnt_d   = '0;
        ack_d      = '0;
      end else begin
        wdt_cnt_d = wdt_cnt_q + CntOne;
      end
    end
`endif

    ch_rstn_d = ch_rel_d & ~sw_busy_d;
  end

  always_ff @(posedge osc_clk or negedge rstn_s) begin
    if (!rstn_s) begin
      state_q    <= StPor;
      cnt_q      <= '0;
      stage_q    <= '0;
      ch_rel_q   <= '0;
      ch_rstn_q  <= '0;
      seq_done_q <= 1'b0;
      req_q      <= '0;
      sw_busy_q  <= '0;
      sw_cnt_q   <= '0;
      ack_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      stage_q    <= stage_d;
      ch_rel_q   <= ch_rel_d;
      ch_rstn_q  <= ch_rstn_d;
      seq_done_q <= seq_done_d;
      req_q      <= sw_rst_req;
      sw_busy_q  <= sw_busy_d;
      sw_cnt_q   <= sw_cnt_d;
      ack_q      <= ack_d;
    end
  end

`ifdef RST_SEQ_WDT_EN
  always_ff @(posedge osc_clk or negedge rstn_s) begin
    if (!rstn_s) begin
      wdt_cnt_q  <= '0;
      wdt_fire_q <= 1'b0;
    end else begin
      wdt_cnt_q  <= wdt_cnt_d;
      wdt_fire_q <= wdt_fire_d;
    end
  end

  assign wdt_fired = wdt_fire_q;
`endif

  assign ch_rstn    = ch_rstn_q;
  assign sw_rst_ack = ack_q;
  assign seq_done   = seq_done_q;

endmodule

// File: tb/tb_rst_seq_gen.sv
// Self-checking bench for rst_seq_gen. Expected outputs come from a timeline
// model: edges elapsed since the sequence (re)started, per-channel software
// reset end times, and the time of the last watchdog kick.
module tb_rst_seq_gen;

  localparam int NCH = 4;
  localparam int POR = 12;
  localparam int STG = 8;
  localparam int SW  = 4;
  localparam int WDT = 32;
`ifdef RST_SEQ_WDT_EN
  localparam bit WDT_ON = 1'b1;
`else
  localparam bit WDT_ON = 1'b0;
`endif

  logic           osc_clk = 1'b0;
  logic           sys_rstn;
  logic [NCH-1:0] sw_rst_req;
  logic [NCH-1:0] ch_rstn;
  logic [NCH-1:0] sw_rst_ack;
  logic           seq_done;
  logic           kick;
`ifdef RST_SEQ_WDT_EN
  logic           wdt_fired;
`endif

  always #5 osc_clk = ~osc_clk;

  rst_seq_gen #(
    .NUM_CH     (NCH),
    .CNT_W      (16),
    .POR_DLY    (POR),
    .STAGE_DLY  (STG),
`ifdef RST_SEQ_WDT_EN
    .WDT_TO     (WDT),
`endif
    .SW_RST_CYC (SW)
  ) u_dut (
    .osc_clk    (osc_clk),
    .sys_rstn   (sys_rstn),
    .sw_rst_req (sw_rst_req),
`ifdef RST_SEQ_WDT_EN
    .wdt_kick   (kick),
    .wdt_fired  (wdt_fired),
`endif
    .ch_rstn    (ch_rstn),
    .sw_rst_ack (sw_rst_ack),
    .seq_done   (seq_done)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int             t;          // edges since sequence start
  int             base;       // edge at which channel 0 is released
  int             sw_end[NCH];// edge at which a software reset ends (-1 none)
  int             wd_ref;     // edge of last watchdog restart point
  logic [NCH-1:0] prev_req;
  bit             fired_exp;

  function automatic int run_time();
    return base + (NCH - 1) * STG;
  endfunction

  task automatic restart(input int b);
    t    = 0;
    base = b;
    for (int k = 0; k < NCH; k++) sw_end[k] = -1;
    wd_ref = run_time();
  endtask

  task automatic model_sys_reset();
    restart(POR + 2);        // two synchroniser edges precede the power-on count
    prev_req  = '0;
    fired_exp = 1'b0;
  endtask

  task automatic model_step();
    bit run_before;
    run_before = (t >= run_time());
    fired_exp  = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (run_before && sw_rst_req[k] && !prev_req[k] && (t >= sw_end[k]))
        sw_end[k] = t + 1 + SW;
    end
    prev_req = sw_rst_req;
    if (run_before && WDT_ON) begin
      if (kick) begin
        wd_ref = t + 1;
      end else if (t + 1 == wd_ref + WDT) begin
        restart(POR);
        fired_exp = 1'b1;
        return;
      end
    end
    t++;
  endtask

  task automatic compare_all();
    logic [NCH-1:0] ch_e, ack_e;
    for (int k = 0; k < NCH; k++) begin
      ch_e[k]  = (t >= base + k * STG) && (t >= sw_end[k]);
      ack_e[k] = (t == sw_end[k]);
    end
    check_eq("ch_rstn", 32'(ch_rstn), 32'(ch_e));
    check_eq("sw_rst_ack", 32'(sw_rst_ack), 32'(ack_e));
    check_eq("seq_done", 32'(seq_done), 32'(t >= run_time()));
`ifdef RST_SEQ_WDT_EN
    check_eq("wdt_fired", 32'(wdt_fired), 32'(fired_exp));
`endif
  endtask

  // ---------------- stimulus ----------------
  int cyc = 0;
  int kick_mode = 1;          // 0 none, 1 every 20 cycles, 2 random

  task automatic step();
    @(posedge osc_clk);
    if (sys_rstn) model_step();
    @(negedge osc_clk);
    compare_all();
  endtask

  task automatic run_cycles(input int n, input bit rnd);
    repeat (n) begin
      if (rnd) sw_rst_req = sw_rst_req ^ (NCH'($urandom) & NCH'($urandom));
      case (kick_mode)
        1:       kick = WDT_ON && (cyc % 20 == 0);
        2:       kick = WDT_ON && ($urandom_range(0, 39) == 0);
        default: kick = 1'b0;
      endcase
      cyc++;
      step();
    end
  endtask

  task automatic assert_reset();
    sys_rstn = 1'b0;
    model_sys_reset();
    #1;
    compare_all();
  endtask

  initial begin
    sys_rstn   = 1'b0;
    sw_rst_req = '0;
    kick       = 1'b0;
    model_sys_reset();
    run_cycles(3, 1'b0);

    // Power-on sequence with random (ignored) requests, then into RUN.
    sys_rstn = 1'b1;
    run_cycles(44, 1'b1);

    // Directed software resets.
    sw_rst_req = '0;      run_cycles(2, 1'b0);
    sw_rst_req = 4'b0100; run_cycles(1, 1'b0);
    sw_rst_req = '0;      run_cycles(8, 1'b0);
    sw_rst_req = 4'b0010; run_cycles(20, 1'b0);
    sw_rst_req = '0;      run_cycles(3, 1'b0);
    sw_rst_req = 4'b1001; run_cycles(1, 1'b0);
    sw_rst_req = '0;      run_cycles(8, 1'b0);

    // Random requests and sparse kicks.
    kick_mode = 2;
    run_cycles(300, 1'b1);

    // No kicks: watchdog expiry and resequence (no effect without the watchdog).
    kick_mode = 0;
    sw_rst_req = '0;
    run_cycles(80, 1'b0);

    // Reset in the middle of staged release, with request pulses during REL.
    kick_mode = 1;
    assert_reset();
    run_cycles(3, 1'b0);
    sys_rstn = 1'b1;
    run_cycles(26, 1'b1);
    assert_reset();
    run_cycles(3, 1'b1);
    sys_rstn = 1'b1;
    run_cycles(30, 1'b1);
    sw_rst_req = '0;
    run_cycles(20, 1'b0);

    // Reset in the middle of a software reset, then a final random run.
    sw_rst_req = 4'b1111; run_cycles(2, 1'b0);
    assert_reset();
    run_cycles(2, 1'b0);
    sys_rstn = 1'b1;
    kick_mode = 2;
    run_cycles(250, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
